crc_packet_tx: RTL and testbench

Transmit-side counterpart of the CRC checker. It accepts a packet length and payload bytes from a producer, and emits the packet on two outbound streams:
- count stream: the payload length, one word.
- data stream: each payload byte, then the computed CRC-8 byte.

The checker at the far end recomputes the CRC over the payload words and compares it against the trailing word.

---
 rtl/crc_packet_tx.sv | 195 +++++++++++++++++++
 tb/tb_crc_packet_tx.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/crc_packet_tx.sv
// CRC-8 packet transmitter: emits a length word, then the payload bytes followed by their CRC-8.
// Optional build macro CRC_TX_ERR_INJECT_EN adds err_inject, which corrupts the CRC word's LSB for one packet.
module crc_packet_tx #(
  parameter int             W    = 8,
  parameter logic [W-1:0]   POLY = 8'h07,
  parameter logic [W-1:0]   INIT = 8'h00
) (
  input  logic         clk,
  input  logic         rst,
`ifdef CRC_TX_ERR_INJECT_EN
  input  logic         err_inject,
`endif
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [W-1:0] cmd_len,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         cnt_valid,
  input  logic         cnt_ready,
  output logic [W-1:0] cnt_data,
  output logic         dat_valid,
  input  logic         dat_ready,
  output logic [W-1:0] dat_data,
  output logic         dat_last,
  output logic         done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_PAYLOAD,
    S_CRC,
    S_DONE
  } state_t;

  // MSB-first, non-reflected CRC update over one byte already XORed into the register.
  function automatic logic [W-1:0] crc8_step(input logic [W-1:0] c);
    logic [W-1:0] r;
    r = c;
    for (int i = 0; i < W; i++) begin
      r = r[W-1] ? ((r << 1) ^ POLY) : (r << 1);
    end
    return r;
  endfunction

  state_t         state_q, state_d;
  logic [W-1:0]   remaining_q, remaining_d;
  logic [W-1:0]   crc_q, crc_d;
  logic           cmd_ready_q, cmd_ready_d;
  logic           cnt_valid_q, cnt_valid_d;
  logic [W-1:0]   cnt_data_q, cnt_data_d;
  logic           dat_valid_q, dat_valid_d;
  logic [W-1:0]   dat_data_q, dat_data_d;
  logic           dat_last_q, dat_last_d;
  logic           done_q, done_d;
  logic [W-1:0]   crc_word;
  logic           cmd_fire, cnt_fire, in_fire, dat_fire, out_free;

`ifdef CRC_TX_ERR_INJECT_EN
  logic           err_q, err_d;
  assign crc_word = crc_q ^ {{(W-1){1'b0}}, err_q};
`else
  assign crc_word = crc_q;
`endif

  // The single output register may be refilled in the same cycle it drains.
  assign out_free = !dat_valid_q || dat_ready;
  assign in_ready = (state_q == S_PAYLOAD) && (remaining_q != '0) && out_free;

  assign cmd_fire = cmd_valid && cmd_ready_q;
  assign cnt_fire = cnt_valid_q && cnt_ready;
  assign in_fire  = in_valid && in_ready;
  assign dat_fire = dat_valid_q && dat_ready;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    crc_d       = crc_q;
    cnt_valid_d = cnt_valid_q;
    cnt_data_d  = cnt_data_q;
    dat_valid_d = dat_valid_q;
    dat_data_d  = dat_data_q;
    dat_last_d  = dat_last_q;
    done_d      = 1'b0;
`ifdef CRC_TX_ERR_INJECT_EN
    err_d       = err_q;
`endif

    if (dat_fire) begin
      dat_valid_d = 1'b0;
      dat_last_d  = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_fire) begin
          remaining_d = cmd_len;
          crc_d       = INIT;
          cnt_data_d  = cmd_len;
          cnt_valid_d = 1'b1;
          state_d     = S_COUNT;
`ifdef CRC_TX_ERR_INJECT_EN
          err_d       = err_inject;
`endif
        end
      end
      S_COUNT: begin
        if (cnt_fire) begin
          cnt_valid_d = 1'b0;
          state_d     = (remaining_q != '0) ? S_PAYLOAD : S_CRC;
        end
      end
      S_PAYLOAD: begin
        if (in_fire) begin
          dat_data_d  = in_data;
          dat_valid_d = 1'b1;
          crc_d       = crc8_step(crc_q ^ in_data);
          remaining_d = remaining_q - 1'b1;
          if (remaining_d == '0) begin
            state_d = S_CRC;
          end
        end
      end
      S_CRC: begin
        // dat_last marks that the CRC word already sits in the output register.
        if (dat_last_q) begin
          if (dat_fire) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end else if (out_free) begin
          dat_data_d  = crc_word;
          dat_valid_d = 1'b1;
          dat_last_d  = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    cmd_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      crc_q       <= INIT;
      cmd_ready_q <= 1'b0;
      cnt_valid_q <= 1'b0;
      cnt_data_q  <= '0;
      dat_valid_q <= 1'b0;
      dat_data_q  <= '0;
      dat_last_q  <= 1'b0;
      done_q      <= 1'b0;
`ifdef CRC_TX_ERR_INJECT_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      crc_q       <= crc_d;
      cmd_ready_q <= cmd_ready_d;
      cnt_valid_q <= cnt_valid_d;
      cnt_data_q  <= cnt_data_d;
      dat_valid_q <= dat_valid_d;
      dat_data_q  <= dat_data_d;
      dat_last_q  <= dat_last_d;
      done_q      <= done_d;
`ifdef CRC_TX_ERR_INJECT_EN
      err_q       <= err_d;
`endif
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign cnt_valid = cnt_valid_q;
  assign cnt_data  = cnt_data_q;
  assign dat_valid = dat_valid_q;
  assign dat_data  = dat_data_q;
  assign dat_last  = dat_last_q;
  assign done      = done_q;

  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    in_fire |-> (remaining_q != '0));

  a_one_stream: assert property (@(posedge clk) disable iff (rst)
    !(cnt_valid_q && dat_valid_q));

endmodule

// File: tb/tb_crc_packet_tx.sv
// Randomized self-checking bench for crc_packet_tx against a bit-serial polynomial-division CRC model.
module tb_crc_packet_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_len;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       cnt_valid;
  logic       cnt_ready;
  logic [7:0] cnt_data;
  logic       dat_valid;
  logic       dat_ready;
  logic [7:0] dat_data;
  logic       dat_last;
  logic       done;
`ifdef CRC_TX_ERR_INJECT_EN
  logic       err_inject;
`endif

  int         n_total = 0;
  int         n_pass  = 0;
  logic [7:0] pl [256];

  always #5 clk = ~clk;

  crc_packet_tx dut (
    .clk       (clk),
    .rst       (rst),
`ifdef CRC_TX_ERR_INJECT_EN
    .err_inject(err_inject),
`endif
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_len   (cmd_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .cnt_valid (cnt_valid),
    .cnt_ready (cnt_ready),
    .cnt_data  (cnt_data),
    .dat_valid (dat_valid),
    .dat_ready (dat_ready),
    .dat_data  (dat_data),
    .dat_last  (dat_last),
    .done      (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Remainder of (message * x^8) mod (x^8 + POLY), shifting in one message bit at a time.
  function automatic logic [7:0] ref_crc(input int len);
    logic [7:0] r;
    logic       b;
    r = 8'h00;
    for (int i = 0; i < len * 8 + 8; i++) begin
      b = (i < len * 8) ? pl[i / 8][7 - (i % 8)] : 1'b0;
      if (r[7]) r = {r[6:0], b} ^ 8'h07;
      else      r = {r[6:0], b};
    end
    return r;
  endfunction

  task automatic run_packet(input int len, input int cnt_stall, input bit rand_rdy,
                            input logic [7:0] exp_crc);
    int         idx, nwords, ncnt, ndone, cyc;
    bit         pv_stall, saw_in_ready;
    logic [7:0] pv_dd;
    idx = 0; nwords = 0; ncnt = 0; ndone = 0;
    pv_stall = 1'b0; saw_in_ready = 1'b0; pv_dd = 8'h00;

    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_len   = len[7:0];
    cyc = 0;
    while (!cmd_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("cmd_accept", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("cnt_latency", 32'(cnt_valid), 32'd1);

    for (cyc = 0; cyc < 3000 && ndone == 0; cyc++) begin
      cnt_ready = (cyc >= cnt_stall);
      dat_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid  = (idx < len);
      in_data   = (idx < len) ? pl[idx] : 8'h00;
      #1;
      if (pv_stall) begin
        check("stall_valid", 32'(dat_valid), 32'd1);
        check("stall_data", 32'(dat_data), 32'(pv_dd));
      end
      if (cyc < cnt_stall && ncnt == 0) begin
        check("cnt_hold_valid", 32'(cnt_valid), 32'd1);
        check("cnt_hold_data", 32'(cnt_data), 32'(len));
      end
      if (cnt_valid && dat_valid) check("one_stream", 32'd1, 32'd0);
      if (len == 0 && in_ready) saw_in_ready = 1'b1;
      if (cnt_valid && cnt_ready) begin
        check("cnt_data", 32'(cnt_data), 32'(len));
        ncnt++;
      end
      if (in_valid && in_ready) begin
        check("in_after_cnt", 32'(ncnt), 32'd1);
        idx++;
      end
      if (dat_valid && dat_ready) begin
        if (nwords < len) begin
          check("payload", 32'(dat_data), 32'(pl[nwords]));
          check("payload_last", 32'(dat_last), 32'd0);
        end else if (nwords == len) begin
          check("crc_word", 32'(dat_data), 32'(exp_crc));
          check("crc_last", 32'(dat_last), 32'd1);
        end else begin
          check("extra_word", 32'(nwords), 32'(len));
        end
        nwords++;
      end
      if (done) ndone++;
      pv_stall = dat_valid && !dat_ready;
      pv_dd    = dat_data;
      @(negedge clk);
    end
    #1;
    check("done_seen", 32'(ndone), 32'd1);
    check("done_pulse", 32'(done), 32'd0);
    check("cnt_words", 32'(ncnt), 32'd1);
    check("dat_words", 32'(nwords), 32'(len + 1));
    check("bytes_taken", 32'(idx), 32'(len));
    if (len == 0) check("len0_no_in_ready", 32'(saw_in_ready), 32'd0);
    in_valid  = 1'b0;
    cnt_ready = 1'b0;
    dat_ready = 1'b0;
  endtask

  initial begin
    int len, cyc, idx;
    rst = 1'b1; cmd_valid = 1'b0; cmd_len = 8'h00; in_valid = 1'b0; in_data = 8'h00;
    cnt_ready = 1'b0; dat_ready = 1'b0;
`ifdef CRC_TX_ERR_INJECT_EN
    err_inject = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_cnt_valid", 32'(cnt_valid), 32'd0);
    check("rst_dat_valid", 32'(dat_valid), 32'd0);
    check("rst_dat_last", 32'(dat_last), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_cnt_data", 32'(cnt_data), 32'd0);
    check("rst_dat_data", 32'(dat_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    pl[0] = 8'h01;
    run_packet(1, 0, 1'b0, 8'h07);
    pl[0] = 8'h01; pl[1] = 8'h02;
    run_packet(2, 0, 1'b0, 8'h1B);
    for (int i = 0; i < 9; i++) pl[i] = 8'h31 + 8'(i);
    run_packet(9, 0, 1'b0, 8'hF4);
    run_packet(0, 5, 1'b0, 8'h00);

    for (int i = 0; i < 16; i++) pl[i] = 8'($urandom);
    run_packet(16, 0, 1'b1, ref_crc(16));
    for (int k = 0; k < 3; k++) begin
      len = int'($urandom_range(0, 40));
      for (int i = 0; i < len; i++) pl[i] = 8'($urandom);
      run_packet(len, int'($urandom_range(0, 3)), 1'b1, ref_crc(len));
    end
    for (int i = 0; i < 255; i++) pl[i] = 8'($urandom);
    run_packet(255, 0, 1'b0, ref_crc(255));

    // Abandon an 8-byte packet after three bytes.
    for (int i = 0; i < 8; i++) pl[i] = 8'($urandom);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_len   = 8'd8;
    cyc = 0;
    while (!cmd_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    idx = 0;
    cyc = 0;
    while (idx < 3 && cyc < 100) begin
      cnt_ready = 1'b1;
      dat_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = pl[idx];
      #1;
      if (in_ready) idx++;
      @(negedge clk);
      cyc++;
    end
    check("abort_bytes", 32'(idx), 32'd3);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_cnt_valid", 32'(cnt_valid), 32'd0);
    check("abort_dat_valid", 32'(dat_valid), 32'd0);
    check("abort_dat_last", 32'(dat_last), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cnt_ready = 1'b0;
    dat_ready = 1'b0;
    @(posedge clk);
    #1;
    check("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    pl[0] = 8'h01;
    run_packet(1, 0, 1'b0, 8'h07);
`ifdef CRC_TX_ERR_INJECT_EN
    err_inject = 1'b1;
    run_packet(1, 0, 1'b0, 8'h06);
    err_inject = 1'b0;
    run_packet(1, 0, 1'b0, 8'h07);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
